// File: rtl/gb_io_pkg.sv
// Shared Game Boy I/O constants: P1/JOYP register address, button bit indices
// and the positions of the P1 select fields.
package gb_io_pkg;

    localparam logic [15:0] JOYP_ADDR = 16'hFF00;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_UP     = 6;
    localparam int BTN_DOWN   = 7;

    localparam int SEL_DIR = 4;
    localparam int SEL_BTN = 5;

endpackage

// File: rtl/gb_joypad_if.sv
// CPU-side bus for the joypad register: strobes, address, data and the
// interrupt request toward the interrupt controller.
interface gb_joypad_if;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        wr;
    logic        rd;
    logic [7:0]  data_out;
    logic        rd_ack;
    logic        int_req;

    modport master (output addr, data_in, wr, rd, input data_out, rd_ack, int_req);
    modport slave  (input addr, data_in, wr, rd, output data_out, rd_ack, int_req);
endinterface

// File: rtl/gb_sync_bus.sv
// N-bit multi-flop synchronizer, asynchronously reset to zero.
module gb_sync_bus #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gb_joypad.sv
// Game Boy P1/JOYP register: synchronized buttons, 2x4 select matrix, read port
// and falling-edge interrupt. Define JOYPAD_LATCH_EN to latch short presses.
module gb_joypad
    import gb_io_pkg::*;
#(
    parameter logic [15:0] JOYP_ADDR   = gb_io_pkg::JOYP_ADDR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [7:0]     buttons,
    gb_joypad_if.slave     bus
);

    logic [7:0] bsync;
    logic [7:0] pressed;
    logic [1:0] sel;
    logic [3:0] lines;
    logic [3:0] lines_q;
    logic       hit;
    logic       unused_data;

    gb_sync_bus #(.N(8), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (buttons),
        .q     (bsync)
    );

    assign hit         = (bus.addr == JOYP_ADDR);
    assign unused_data = ^{bus.data_in[7:6], bus.data_in[3:0]};

`ifdef JOYPAD_LATCH_EN
    // Sticky bits hold a press until a read of its group sees it released.
    logic [7:0] sticky;
    logic [7:0] bsync_q;
    logic [7:0] group_sel;
    logic [7:0] clr;

    assign group_sel = {{4{~sel[0]}}, {4{~sel[1]}}};
    assign clr       = {8{bus.rd && hit}} & group_sel & ~bsync;
    assign pressed   = bsync | sticky;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky  <= 8'h00;
            bsync_q <= 8'h00;
        end else begin
            bsync_q <= bsync;
            sticky  <= (sticky & ~clr) | (bsync & ~bsync_q);
        end
    end
`else
    assign pressed = bsync;
`endif

    always_comb begin
        lines = 4'hF;
        lines = ~(({4{~sel[0]}} & pressed[BTN_DOWN:BTN_RIGHT]) |
                  ({4{~sel[1]}} & pressed[BTN_START:BTN_A]));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel          <= 2'b11;
            lines_q      <= 4'hF;
            bus.data_out <= 8'hFF;
            bus.rd_ack   <= 1'b0;
            bus.int_req  <= 1'b0;
        end else begin
            if (bus.wr && hit) sel <= bus.data_in[SEL_BTN:SEL_DIR];
            // Read captures the pre-write sel when rd and wr coincide.
            if (bus.rd && hit) bus.data_out <= {2'b11, sel, lines};
            bus.rd_ack  <= bus.rd && hit;
            lines_q     <= lines;
            bus.int_req <= |(lines_q & ~lines);
        end
    end

endmodule

// File: tb/tb_gb_joypad.sv
// Self-checking bench for gb_joypad: directed test-plan steps plus randomized
// bus/button traffic checked every cycle against a behavioural model.
module tb_gb_joypad;
    import gb_io_pkg::*;

    localparam int SYNC_STAGES = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] buttons = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         int_cnt = 0;

    gb_joypad_if bus ();

    gb_joypad #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clock   (clock),
        .reset   (reset),
        .buttons (buttons),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: buttons are seen SYNC_STAGES samples late; lines follow
    // the P1 truth table; an interrupt is any line that was high and is now low.
    logic [7:0] hist [SYNC_STAGES];
    logic [1:0] m_sel;
    logic [3:0] m_prev;
    logic [7:0] m_sticky, m_bprev;
    logic [7:0] exp_data;
    logic       exp_ack, exp_int;

    function automatic logic [3:0] p1_lines(input logic [7:0] p, input logic [1:0] s);
        logic [3:0] l = 4'hF;
        for (int i = 0; i < 4; i++)
            if ((s[0] == 1'b0 && p[4+i]) || (s[1] == 1'b0 && p[i])) l[i] = 1'b0;
        return l;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) hist[k] = 8'h00;
            m_sel = 2'b11; m_prev = 4'hF; m_sticky = 8'h00; m_bprev = 8'h00;
            exp_data = 8'hFF; exp_ack = 1'b0; exp_int = 1'b0;
        end else begin
            logic [7:0] bs, p;
            logic [3:0] l;
            logic       hit;
            bs  = hist[SYNC_STAGES-1];
            p   = bs;
`ifdef JOYPAD_LATCH_EN
            p   = bs | m_sticky;
`endif
            l   = p1_lines(p, m_sel);
            hit = (bus.addr == 16'hFF00);
            exp_int = |(m_prev & ~l);
            m_prev  = l;
            exp_ack = bus.rd && hit;
            if (bus.rd && hit) exp_data = {2'b11, m_sel, l};
            for (int i = 0; i < 8; i++) begin
                logic grp;
                grp = (i >= 4) ? !m_sel[0] : !m_sel[1];
                if (bs[i] && !m_bprev[i]) m_sticky[i] = 1'b1;
                else if (bus.rd && hit && grp && !bs[i]) m_sticky[i] = 1'b0;
            end
            m_bprev = bs;
            if (bus.wr && hit) m_sel = bus.data_in[5:4];
            for (int k = SYNC_STAGES-1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = buttons;
        end
    end

    always @(negedge clock) begin
        if (bus.int_req) int_cnt++;
        chk("int_req", bus.int_req, exp_int);
        chk("rd_ack", bus.rd_ack, exp_ack);
        chk("data_out", bus.data_out, exp_data);
    end

    task automatic do_write(input logic [7:0] d);
        bus.addr = 16'hFF00; bus.data_in = d; bus.wr = 1'b1;
        @(negedge clock);
        bus.wr = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] exp);
        bus.addr = 16'hFF00; bus.rd = 1'b1;
        @(negedge clock);
        bus.rd = 1'b0;
        chk({tag, "_ack"}, bus.rd_ack, 1'b1);
        chk(tag, bus.data_out, exp);
    endtask

    initial begin
        int c0;
        bus.addr = 16'h0000; bus.data_in = 8'h00; bus.wr = 1'b0; bus.rd = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // 1: reset read
        do_read("reset_read", 8'hFF);
        @(negedge clock);
        chk("ack_one_cycle", bus.rd_ack, 1'b0);
        chk("no_int_after_reset", int_cnt, 0);

        // 2: directions selected, Right pressed
        do_write(8'h20);
        c0 = int_cnt;
        buttons = 8'h10;
        repeat (2) @(negedge clock);
        chk("int_latency_early", bus.int_req, 1'b0);
        @(negedge clock);
        chk("int_latency", bus.int_req, 1'b1);
        @(negedge clock);
        chk("int_one_cycle", bus.int_req, 1'b0);
        do_read("right_read", 8'hEE);
        repeat (6) @(negedge clock);
        chk("int_single_pulse", int_cnt - c0, 1);

        // 3: action group, A+Start, then both groups with Down
        do_write(8'h10);
        buttons = 8'h09;
        repeat (4) @(negedge clock);
        do_read("actions_read", 8'hD6);
        buttons = 8'h89;
        do_write(8'h00);
        repeat (4) @(negedge clock);
        do_read("both_read", 8'hC6);

        // 4: same-cycle read and write
        buttons = 8'h10;
        do_write(8'h30);
        repeat (4) @(negedge clock);
        c0 = int_cnt;
        bus.addr = 16'hFF00; bus.data_in = 8'h20; bus.rd = 1'b1; bus.wr = 1'b1;
        @(negedge clock);
        bus.rd = 1'b0; bus.wr = 1'b0;
        chk("rdwr_read", bus.data_out, 8'hFF);
        @(negedge clock);
        chk("rdwr_int", bus.int_req, 1'b1);
        do_read("rdwr_next_read", 8'hEE);
        chk("rdwr_int_count", int_cnt - c0, 1);

        // 5: asynchronous reset while Right is pressed and selected
        bus.addr = 16'hFF00; bus.rd = 1'b1;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_data_out", bus.data_out, 8'hFF);
        chk("async_rd_ack", bus.rd_ack, 1'b0);
        chk("async_int_req", bus.int_req, 1'b0);
        bus.rd = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        c0 = int_cnt;
        repeat (5) @(negedge clock);
        chk("no_int_on_release", int_cnt - c0, 0);
        do_write(8'h20);
        repeat (3) @(negedge clock);
        chk("int_after_rewrite", int_cnt - c0, 1);
        do_read("after_reset_read", 8'hEE);

        // 6: one-cycle B press with actions selected
        buttons = 8'h00;
        do_write(8'h10);
        repeat (4) @(negedge clock);
        buttons = 8'h02;
        @(negedge clock);
        buttons = 8'h00;
        repeat (4) @(negedge clock);
`ifdef JOYPAD_LATCH_EN
        do_read("latch_first", 8'hDD);
        do_read("latch_second", 8'hDF);
`else
        do_read("short_press", 8'hDF);
`endif

        // Randomized traffic; the per-cycle model checks cover it.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) buttons = 8'($urandom);
            bus.addr    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFF00;
            bus.data_in = 8'($urandom);
            bus.rd      = ($urandom_range(0, 2) == 0);
            bus.wr      = ($urandom_range(0, 3) == 0);
            @(negedge clock);
        end
        bus.rd = 1'b0; bus.wr = 1'b0;
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
